// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - universal shift/rotate register with load, clear and multi-cycle shifts
// One 1-bit step per SHIFT cycle; op and amount are captured at start so they cannot change mid-run.
module shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ASR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam logic [AMT_W-1:0] CNT_ZERO = '0;
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_LOAD: begin
              q_d     = d;
              state_d = S_DONE;
            end
            OP_CLEAR: begin
              q_d     = '0;
              so_d    = 1'b0;
              state_d = S_DONE;
            end
            OP_NOP: state_d = S_DONE;
            default: begin
              op_d    = op;
              cnt_d   = amount;
              state_d = (amount == CNT_ZERO) ? S_DONE : S_SHIFT;
            end
          endcase
        end
      end
      S_SHIFT: begin
        // serial_in is taken live each step, unlike the latched op/amount
        unique case (op_q)
          OP_SHL: begin
            q_d  = {q_q[WIDTH-2:0], serial_in};
            so_d = q_q[WIDTH-1];
          end
          OP_SHR: begin
            q_d  = {serial_in, q_q[WIDTH-1:1]};
            so_d = q_q[0];
          end
          OP_ASR: begin
            q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            so_d = q_q[0];
          end
          OP_ROL: begin
            q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            so_d = q_q[WIDTH-1];
          end
          OP_ROR: begin
            q_d  = {q_q[0], q_q[WIDTH-1:1]};
            so_d = q_q[0];
          end
          default: ;
        endcase
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q          = q_q;
  assign serial_out = so_q;
  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// tb/tb_shift_register_universal.sv - directed self-checking bench for shift_register_universal
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_shift_register_universal;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] d;
  logic       serial_in;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       serial_out;

  int checks   = 0;
  int failures = 0;

  shift_register_universal #(.WIDTH(8), .AMT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .amount     (amount),
    .d          (d),
    .serial_in  (serial_in),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .serial_out (serial_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb,
                        input logic ed, input logic eso);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, "_done"}, {7'd0, done}, {7'd0, ed});
    chk({tag, "_so"}, {7'd0, serial_out}, {7'd0, eso});
  endtask

  task automatic go(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dv);
    start = 1'b1; op = o; amount = a; d = dv;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] ror_exp [9];

  initial begin
    ror_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    reset = 1'b1; start = 1'b0; op = 3'b111; amount = 4'd0; d = 8'h00; serial_in = 1'b0;
    tick();
    tick();
    chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Start accepted on the very first edge with reset low
    reset = 1'b0;
    go(3'b000, 4'd0, 8'hA5);
    chk_st("load_a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("load_a5_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

    serial_in = 1'b1;
    go(3'b001, 4'd3, 8'h00);
    chk_st("shl_b0", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("shl_s1", 8'h4B, 1'b1, 1'b0, 1'b1);
    tick();
    chk_st("shl_s2", 8'h97, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("shl_s3", 8'h2F, 1'b0, 1'b1, 1'b1);
    tick();
    chk_st("shl_idle", 8'h2F, 1'b0, 1'b0, 1'b1);

    go(3'b111, 4'd0, 8'h55);
    chk_st("nop", 8'h2F, 1'b0, 1'b1, 1'b1);
    tick();

    go(3'b000, 4'd0, 8'h90);
    chk_st("load_90", 8'h90, 1'b0, 1'b1, 1'b1);
    tick();
    go(3'b011, 4'd2, 8'h00);
    chk_st("asr_b0", 8'h90, 1'b1, 1'b0, 1'b1);
    tick();
    chk_st("asr_s1", 8'hC8, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("asr_s2", 8'hE4, 1'b0, 1'b1, 1'b0);
    tick();

    go(3'b000, 4'd0, 8'h90);
    tick();
    go(3'b010, 4'd0, 8'h00);
    chk_st("shr0", 8'h90, 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("shr0_idle", 8'h90, 1'b0, 1'b0, 1'b0);

    // Serial input is sampled live: vary it between SHR steps
    serial_in = 1'b1;
    go(3'b010, 4'd2, 8'h00);
    tick();
    chk_st("shr_s1", 8'hC8, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    tick();
    chk_st("shr_s2", 8'h64, 1'b0, 1'b1, 1'b0);
    tick();

    go(3'b000, 4'd0, 8'h01);
    tick();
    go(3'b101, 4'd9, 8'h00);
    chk_st("ror_b0", 8'h01, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin
        start = 1'b1; op = 3'b000; d = 8'hFF; amount = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk($sformatf("ror_q%0d", k + 1), q, ror_exp[k]);
      chk($sformatf("ror_busy%0d", k + 1), {7'd0, busy}, (k < 8) ? 8'h01 : 8'h00);
    end
    chk_st("ror_end", 8'h80, 1'b0, 1'b1, 1'b1);
    // Start presented during DONE must be dropped, not queued
    start = 1'b1; op = 3'b000; d = 8'hFF;
    tick();
    start = 1'b0;
    chk_st("done_ign", 8'h80, 1'b0, 1'b0, 1'b1);
    tick();
    chk_st("done_noq", 8'h80, 1'b0, 1'b0, 1'b1);

    go(3'b110, 4'd0, 8'hFF);
    chk_st("clear", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    go(3'b000, 4'd0, 8'h81);
    tick();
    go(3'b100, 4'd5, 8'h00);
    tick();
    chk_st("rol_s1", 8'h03, 1'b1, 1'b0, 1'b1);
    tick();
    chk_st("rol_s2", 8'h06, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_st("rol_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_st("rol_nodone", 8'h00, 1'b0, 1'b0, 1'b0);
    go(3'b000, 4'd0, 8'h3C);
    chk_st("load_3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("final_idle", 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
